// File: rtl/div_pkg.sv
// Shared types and constants for the sequential RV32M divider.
package div_pkg;

   localparam int DIV_XLEN  = 32;
   localparam int DIV_CNT_W = 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } div_state_e;

   localparam int OP_UNSIGNED = 0;
   localparam int OP_REM      = 1;

   localparam logic [DIV_XLEN-1:0] INT_MIN  = 32'h8000_0000;
   localparam logic [DIV_XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] dsr_i,
   input  logic            bit_i,
   output logic [XLEN-1:0] rem_o,
   output logic            q_o
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // The partial remainder never reaches 2^(XLEN-1) before the last shift, so bit XLEN
   // of the shifted value is zero and diff[XLEN] is a clean borrow.
   assign shifted = {rem_i, bit_i};
   assign diff    = shifted - {1'b0, dsr_i};
   assign q_o     = ~diff[XLEN];
   assign rem_o   = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/div_unit_seq.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional result cache for repeated operands: define DIV_RESULT_CACHE_EN.
module div_unit_seq
   import div_pkg::*;
#(
   parameter int XLEN  = DIV_XLEN,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic [1:0]      OP,
   input  logic [XLEN-1:0] DATA1,
   input  logic [XLEN-1:0] DATA2,
   output logic [XLEN-1:0] RESULT,
   output logic            BUSY,
   output logic            DONE
);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  dvd_q, dvd_d;
   logic [XLEN-1:0]  dsr_q, dsr_d;
   logic [XLEN-1:0]  rem_q, rem_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic             rem_sel_q, rem_sel_d;
   logic             neg_q, neg_d;
   logic             sgn_q, sgn_d;
   logic             done_q, done_d;

   logic             in_signed, is_zero, is_ovf;
   logic [XLEN-1:0]  a_abs, b_abs, quo_fix, rem_fix, step_rem;
   logic             step_q;

   assign in_signed = ~OP[OP_UNSIGNED];
   assign a_abs     = (in_signed && DATA1[XLEN-1]) ? -DATA1 : DATA1;
   assign b_abs     = (in_signed && DATA2[XLEN-1]) ? -DATA2 : DATA2;
   assign is_zero   = (DATA2 == '0);
   assign is_ovf    = in_signed && (DATA1 == INT_MIN) && (DATA2 == ALL_ONES);

   // Quotient sign follows the operand-sign XOR; remainder follows the dividend.
   assign quo_fix = neg_q ? -dvd_q : dvd_q;
   assign rem_fix = sgn_q ? -rem_q : rem_q;

   div_step #(.XLEN(XLEN)) u_step (
      .rem_i (rem_q),
      .dsr_i (dsr_q),
      .bit_i (dvd_q[XLEN-1]),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

`ifdef DIV_RESULT_CACHE_EN
   logic            cache_vld_q, cache_vld_d;
   logic            cache_u_q, cache_u_d;
   logic            op_u_q, op_u_d;
   logic [XLEN-1:0] cache_a_q, cache_a_d, cache_b_q, cache_b_d;
   logic [XLEN-1:0] cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;
   logic [XLEN-1:0] raw_a_q, raw_a_d, raw_b_q, raw_b_d;
   logic            cache_hit;

   assign cache_hit = cache_vld_q && (DATA1 == cache_a_q) && (DATA2 == cache_b_q)
                      && (OP[OP_UNSIGNED] == cache_u_q);
`endif

   // NOTE: every signal written here gets its default first, so no path leaves a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvd_d     = dvd_q;
      dsr_d     = dsr_q;
      rem_d     = rem_q;
      result_d  = result_q;
      rem_sel_d = rem_sel_q;
      neg_d     = neg_q;
      sgn_d     = sgn_q;
      done_d    = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
      cache_vld_d = cache_vld_q;
      cache_u_d   = cache_u_q;
      cache_a_d   = cache_a_q;
      cache_b_d   = cache_b_q;
      cache_quo_d = cache_quo_q;
      cache_rem_d = cache_rem_q;
      op_u_d      = op_u_q;
      raw_a_d     = raw_a_q;
      raw_b_d     = raw_b_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (START) begin
               if (is_zero) begin
                  result_d = OP[OP_REM] ? DATA1 : ALL_ONES;
                  done_d   = 1'b1;
               end else if (is_ovf) begin
                  result_d = OP[OP_REM] ? '0 : INT_MIN;
                  done_d   = 1'b1;
`ifdef DIV_RESULT_CACHE_EN
               end else if (cache_hit) begin
                  result_d = OP[OP_REM] ? cache_rem_q : cache_quo_q;
                  done_d   = 1'b1;
`endif
               end else begin
                  rem_sel_d = OP[OP_REM];
                  neg_d     = in_signed && (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
                  sgn_d     = in_signed && DATA1[XLEN-1];
                  dvd_d     = a_abs;
                  dsr_d     = b_abs;
                  rem_d     = '0;
                  cnt_d     = CNT_W'(XLEN - 1);
                  state_d   = S_CALC;
`ifdef DIV_RESULT_CACHE_EN
                  op_u_d    = OP[OP_UNSIGNED];
                  raw_a_d   = DATA1;
                  raw_b_d   = DATA2;
`endif
               end
            end
         end

         S_CALC: begin
            // Quotient bits shift into the dividend register as its bits shift out.
            rem_d = step_rem;
            dvd_d = {dvd_q[XLEN-2:0], step_q};
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_FIX: begin
            result_d = rem_sel_q ? rem_fix : quo_fix;
            done_d   = 1'b1;
            state_d  = S_IDLE;
`ifdef DIV_RESULT_CACHE_EN
            cache_vld_d = 1'b1;
            cache_u_d   = op_u_q;
            cache_a_d   = raw_a_q;
            cache_b_d   = raw_b_q;
            cache_quo_d = quo_fix;
            cache_rem_d = rem_fix;
`endif
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   // NOTE: datapath registers are always reloaded in IDLE before use, so they carry no reset.
   always_ff @(posedge CLK) begin
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      rem_sel_q <= rem_sel_d;
      neg_q     <= neg_d;
      sgn_q     <= sgn_d;
   end

`ifdef DIV_RESULT_CACHE_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cache_vld_q <= 1'b0;
      end else begin
         cache_vld_q <= cache_vld_d;
      end
   end

   always_ff @(posedge CLK) begin
      cache_u_q   <= cache_u_d;
      cache_a_q   <= cache_a_d;
      cache_b_q   <= cache_b_d;
      cache_quo_q <= cache_quo_d;
      cache_rem_q <= cache_rem_d;
      op_u_q      <= op_u_d;
      raw_a_q     <= raw_a_d;
      raw_b_q     <= raw_b_d;
   end
`endif

   assign RESULT = result_q;
   assign DONE   = done_q;
   assign BUSY   = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_unit_seq.sv
// Scoreboard bench for div_unit_seq: directed RV32M corner cases plus random operations,
// checked against an arithmetic reference model (also models DIV_RESULT_CACHE_EN when defined).
module tb_div_unit_seq;

   localparam int XLEN     = 32;
   localparam int FULL_LAT = XLEN + 2;
`ifdef DIV_RESULT_CACHE_EN
   localparam bit CACHE_ON = 1'b1;
`else
   localparam bit CACHE_ON = 1'b0;
`endif

   logic            CLK = 1'b0;
   logic            RESET = 1'b1;
   logic            START = 1'b0;
   logic [1:0]      OP = '0;
   logic [XLEN-1:0] DATA1 = '0;
   logic [XLEN-1:0] DATA2 = '0;
   logic [XLEN-1:0] RESULT;
   logic            BUSY;
   logic            DONE;

   div_unit_seq dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .START  (START),
      .OP     (OP),
      .DATA1  (DATA1),
      .DATA2  (DATA2),
      .RESULT (RESULT),
      .BUSY   (BUSY),
      .DONE   (DONE)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   free_cyc = 0;
   int   bfrom = 0;
   int   buntil = 0;

   bit          c_vld = 1'b0;
   logic [31:0] c_a, c_b;
   logic        c_u;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (op[0]) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a;
         r = 0;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
      return op[1] ? r : q;
   endfunction

   // Monitor: one pass per cycle, 1 time unit after the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         cyc++;
         if (DONE) begin
            if (exp_q.size() == 0) begin
               check("spurious_done", 32'(DONE), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("result", RESULT, e.res);
               check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("done_missing", 32'(DONE), 32'd1);
         end
         check("busy", 32'(BUSY), 32'(cyc >= bfrom && cyc < buntil));
      end
   end

   // Called at a falling edge; drives START for one cycle, then scrambles the inputs.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      bit   special, hit;
      int   lat;
      START = 1'b1;
      OP    = op;
      DATA1 = a;
      DATA2 = b;
      if (cyc >= free_cyc) begin
         special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
         hit     = CACHE_ON && c_vld && c_a == a && c_b == b && c_u == op[0] && !special;
         lat     = (special || hit) ? 1 : FULL_LAT;
         e.res   = ref_result(op, a, b);
         e.cyc   = cyc + lat;
         exp_q.push_back(e);
         free_cyc = cyc + lat;
         if (!special && !hit) begin
            bfrom  = cyc + 1;
            buntil = cyc + lat;
            c_vld  = 1'b1;
            c_a    = a;
            c_b    = b;
            c_u    = op[0];
         end
      end
      @(negedge CLK);
      START = 1'b0;
      OP    = 2'($urandom);
      DATA1 = $urandom;
      DATA2 = $urandom;
   endtask

   task automatic wait_free();
      int guard = 0;
      while (cyc < free_cyc && guard < 200) begin
         @(negedge CLK);
         guard++;
      end
      if (guard >= 200) check("wait_timeout", 32'(guard), 32'd0);
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      exp_q.delete();
      free_cyc = cyc + 1;
      if (buntil > cyc + 1) buntil = cyc + 1;
      c_vld = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
      check("reset_result", RESULT, 32'd0);
      check("reset_busy", 32'(BUSY), 32'd0);
      check("reset_done", 32'(DONE), 32'd0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'd0;
         3: return 32'($urandom_range(1, 20));
         4: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] a, b;
      logic [1:0]  op;

      repeat (2) @(negedge CLK);
      do_reset();

      // Quotient/remainder, signed and unsigned views of a negative dividend.
      wait_free(); issue(2'b00, 32'd100, 32'd7);
      wait_free(); issue(2'b10, 32'd100, 32'd7);
      wait_free(); issue(2'b10, 32'hFFFF_FFF9, 32'd2);
      wait_free(); issue(2'b00, 32'hFFFF_FFF9, 32'd2);
      wait_free(); issue(2'b01, 32'hFFFF_FFF9, 32'd2);

      // Divide-by-zero and signed overflow, back to back.
      wait_free(); issue(2'b01, 32'd55, 32'd0);
      issue(2'b10, 32'd55, 32'd0);
      issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

      // Reset in the middle of a long divide.
      wait_free(); issue(2'b00, 32'd1000, 32'd3);
      repeat (9) @(negedge CLK);
      do_reset();

      // A second START while busy is dropped; the REM follow-up may hit the cache.
      wait_free(); issue(2'b00, 32'd1000, 32'd3);
      repeat (5) @(negedge CLK);
      issue(2'b01, 32'd9, 32'd4);
      wait_free(); issue(2'b10, 32'd1000, 32'd3);

      a = 32'd1;
      b = 32'd1;
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge CLK);
         wait_free();
         op = 2'($urandom);
         if ($urandom_range(0, 3) != 0) begin
            a = pick_operand();
            b = pick_operand();
         end
         issue(op, a, b);
         if ($urandom_range(0, 5) == 0) begin
            repeat (3) @(negedge CLK);
            issue(2'($urandom), pick_operand(), pick_operand());
         end
      end

      wait_free();
      repeat (3) @(negedge CLK);
      check("drain", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
